// File: rtl/residual_decompress_pkg.sv
// residual_decompress_pkg: shared types, sizes and channel-width helpers for residual_decompress
package residual_decompress_pkg;
  localparam int NUM_PIXELS = 32;
  localparam int WORD_W = 32;
  localparam int RAW_PIX_BITS = 32;
  localparam int MAX_COMP_PIX_BITS = 14;
  typedef logic [3:0][7:0] pixel_rgba_t;
  typedef enum logic [0:0] {IDLE, DECODE} decomp_state_e;
  typedef struct packed {
    logic [7:0] r_min;
    logic [7:0] g_min;
    logic [7:0] b_min;
    logic [7:0] a_min;
    logic skip_r;
    logic skip_g;
    logic skip_b;
    logic skip_a;
    logic [11:0] bits_required;
  } header_t;
  // Channel c: 0=R (bits_required[11:9]) .. 3=A (bits_required[2:0]).
  function automatic logic [3:0] chan_width(input header_t h, input logic [1:0] c);
    logic [3:0] sk;
    logic [3:0][2:0] br;
    sk = {h.skip_a, h.skip_b, h.skip_g, h.skip_r};
    br = {h.bits_required[2:0], h.bits_required[5:3], h.bits_required[8:6], h.bits_required[11:9]};
    return sk[c] ? 4'd0 : {1'b0, br[c]} + 4'd1;
  endfunction
  function automatic logic [5:0] pix_width(input header_t h, input logic raw);
    logic [5:0] s;
    s = 6'd0;
    for (int c = 0; c < 4; c++) s = s + {2'b0, chan_width(h, 2'(c))};
    return raw ? 6'(RAW_PIX_BITS) : s;
  endfunction
endpackage

// File: rtl/residual_decompress_unpack.sv
// residual_field_unpack: splits the low 32 buffer bits into one RGBA pixel (min + residual, or raw bytes)
//   buffer : next pixel's bits, LSB-first R,G,B,A
//   hdr    : latched block header
//   raw    : 1 = raw pixel (bytes taken directly, mins ignored)
//   pixel  : rebuilt pixel, [0]=R .. [3]=A
//   ovf    : per-channel 9-bit sum carry for non-skipped compressed channels
module residual_field_unpack
  import residual_decompress_pkg::*;
(
  input  logic [31:0] buffer,
  input  header_t     hdr,
  input  logic        raw,
  output pixel_rgba_t pixel,
  output logic [3:0]  ovf
);
  pixel_rgba_t mins;
  logic [5:0] off;
  logic [3:0] w;
  logic [31:0] sh;
  logic [8:0] mask;
  logic [8:0] sum;
  assign mins = {hdr.a_min, hdr.b_min, hdr.g_min, hdr.r_min};
  always_comb begin
    off = '0;
    w = '0;
    sh = '0;
    mask = '0;
    sum = '0;
    pixel = '0;
    ovf = '0;
    for (int c = 0; c < 4; c++) begin
      w = chan_width(hdr, 2'(c));
      sh = buffer >> off;
      mask = (9'd1 << w) - 9'd1;
      sum = {1'b0, mins[c]} + {1'b0, sh[7:0] & mask[7:0]};
      pixel[c] = raw ? buffer[8*c +: 8] : sum[7:0];
      ovf[c] = !raw && w != 4'd0 && sum[8];
      off = off + {2'b0, w};
    end
  end
endmodule

// File: rtl/residual_decompress.sv
// residual_decompress: rebuilds 32 RGBA pixels of a block from a header and a packed residual word stream
//   clk, rst (async, active-low)
//   hdr_valid/hdr_ready, hdr, hdr_compressable : block header handshake
//   in_valid/in_ready, in_data                 : payload words, bit 0 consumed first
//   out_valid/out_ready, out_pixel, out_idx, out_last : one pixel per handshake
//   err : sticky channel-overflow flag when RESIDUAL_DECOMP_CHECK_EN is defined, else 0
module residual_decompress
  import residual_decompress_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hdr_valid,
  output logic        hdr_ready,
  input  header_t     hdr,
  input  logic        hdr_compressable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output pixel_rgba_t out_pixel,
  output logic [4:0]  out_idx,
  output logic        out_last,
  output logic        err
);
  decomp_state_e state;
  header_t h;
  logic raw;
  logic [5:0] w;
  logic [63:0] bits;
  logic [6:0] cnt;
  logic [5:0] words;
  logic [5:0] pix;
  pixel_rgba_t px;
  logic [3:0] ovf;
  logic take, ext;
  logic [63:0] kept;
  logic [6:0] base;
  assign hdr_ready = state == IDLE;
  assign in_ready = state == DECODE && cnt <= 7'd32 && words < w;
  assign take = in_valid && in_ready;
  assign ext = state == DECODE && cnt >= {1'b0, w} && pix < 6'(NUM_PIXELS) && (!out_valid || out_ready);
  // Extraction drops W bits first, so a word taken in the same cycle lands at count - W.
  assign kept = ext ? bits >> w : bits;
  assign base = ext ? cnt - {1'b0, w} : cnt;
  residual_field_unpack u_unpack (.buffer(bits[31:0]), .hdr(h), .raw(raw), .pixel(px), .ovf(ovf));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      h <= '0;
      raw <= 1'b0;
      w <= '0;
      bits <= '0;
      cnt <= '0;
      words <= '0;
      pix <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_idx <= '0;
      out_last <= 1'b0;
    end else begin
      if (state == IDLE && hdr_valid) begin
        state <= DECODE;
        h <= hdr;
        raw <= !hdr_compressable;
        w <= pix_width(hdr, !hdr_compressable);
        bits <= '0;
        cnt <= '0;
        words <= '0;
        pix <= '0;
      end else if (state == DECODE) begin
        if (out_valid && out_ready && out_last) state <= IDLE;
        bits <= take ? kept | ({32'b0, in_data} << base) : kept;
        cnt <= base + (take ? 7'd32 : 7'd0);
        words <= words + 6'(take);
        if (ext) begin
          out_pixel <= px;
          out_idx <= pix[4:0];
          out_last <= pix == 6'(NUM_PIXELS - 1);
          pix <= pix + 6'd1;
        end
      end
      out_valid <= ext ? 1'b1 : out_valid && !out_ready;
    end
  end
`ifdef RESIDUAL_DECOMP_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err <= 1'b0;
    else if (ext && |ovf) err <= 1'b1;
  end
`else
  logic unused_ovf;
  assign unused_ovf = ^ovf;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_residual_decompress.sv
// tb_residual_decompress: directed blocks checked against a bit-stream pixel model
module tb_residual_decompress;
  import residual_decompress_pkg::*;
  logic clk = 0, rst = 0, hdr_valid = 0, hdr_compressable = 0, in_valid = 0, out_ready = 0;
  header_t hdr = '0;
  logic [31:0] in_data = '0;
  logic hdr_ready, in_ready, out_valid, out_last, err;
  pixel_rgba_t out_pixel;
  logic [4:0] out_idx;
  int checks = 0, passed = 0;
  logic [37:0] exp_q[$];
  logic [31:0] payload[32];
  logic exp_err = 0;
  logic prev_stall = 0;
  logic [37:0] prev_out = '0;
  always #5 clk = ~clk;
  residual_decompress dut (
    .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr(hdr),
    .hdr_compressable(hdr_compressable), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel), .out_idx(out_idx),
    .out_last(out_last), .err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic header_t mk(input logic [7:0] r, g, b, a, input logic [3:0] sk, input logic [11:0] br);
    header_t x;
    x.r_min = r; x.g_min = g; x.b_min = b; x.a_min = a;
    {x.skip_r, x.skip_g, x.skip_b, x.skip_a} = sk;
    x.bits_required = br;
    return x;
  endfunction
  function automatic int cw(input header_t x, input int c);
    logic [3:0] sk;
    int br[4];
    sk = {x.skip_a, x.skip_b, x.skip_g, x.skip_r};
    br = '{int'(x.bits_required[11:9]), int'(x.bits_required[8:6]), int'(x.bits_required[5:3]), int'(x.bits_required[2:0])};
    return sk[c] ? 0 : br[c] + 1;
  endfunction
  function automatic int pix_bits(input header_t x, input logic comp);
    int w = 0;
    for (int c = 0; c < 4; c++) w += cw(x, c);
    return comp ? w : 32;
  endfunction
  // Reads pixel i straight out of the payload treated as one LSB-first bit stream.
  function automatic logic [31:0] model_pixel(input header_t x, input logic comp, input int i, output logic ov);
    int w, pos, f, sum;
    int mn[4];
    logic [31:0] p;
    mn = '{int'(x.r_min), int'(x.g_min), int'(x.b_min), int'(x.a_min)};
    ov = 0;
    p = '0;
    if (!comp) return payload[i];
    w = pix_bits(x, comp);
    pos = i * w;
    for (int c = 0; c < 4; c++) begin
      f = 0;
      for (int b = 0; b < cw(x, c); b++) f |= int'(payload[(pos + b) / 32][(pos + b) % 32]) << b;
      pos += cw(x, c);
      sum = mn[c] + f;
      p[8*c +: 8] = 8'(sum);
      if (cw(x, c) > 0 && sum > 255) ov = 1;
    end
    return p;
  endfunction
  task automatic build_model(input header_t x, input logic comp);
    logic ov;
    logic [31:0] p;
    for (int i = 0; i < 32; i++) begin
      p = model_pixel(x, comp, i, ov);
`ifdef RESIDUAL_DECOMP_CHECK_EN
      if (ov) exp_err = 1;
`endif
      exp_q.push_back({i == 31, 5'(i), p});
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && prev_stall) chk("stall_hold", {out_last, out_idx, out_pixel}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spare_pixel", 64'(exp_q.size()), 1);
        else chk("pixel", {out_last, out_idx, out_pixel}, exp_q.pop_front());
      end
    end
    prev_stall = rst && out_valid && !out_ready;
    prev_out = {out_last, out_idx, out_pixel};
  end
  task automatic reset_checks(input string t);
    chk({t, "_hdr_ready"}, hdr_ready, 1);
    chk({t, "_in_ready"}, in_ready, 0);
    chk({t, "_out_valid"}, out_valid, 0);
    chk({t, "_out_pixel"}, out_pixel, 0);
    chk({t, "_out_idx"}, out_idx, 0);
    chk({t, "_out_last"}, out_last, 0);
    chk({t, "_err"}, err, 0);
  endtask
  task automatic run_block(input string tag, input header_t x, input logic comp,
                           input int in_pct, input int out_pct, input int abort_at);
    int nw, wi, got, cyc;
    logic hdr_go, extra;
    build_model(x, comp);
    nw = pix_bits(x, comp);
    wi = 0; got = 0; cyc = 0; extra = 0;
    hdr = x; hdr_compressable = comp; hdr_valid = 1; in_valid = 0;
    out_ready = $urandom_range(99) < out_pct;
    while (got < 32 && cyc < 4000) begin
      @(negedge clk);
      hdr_go = hdr_valid && hdr_ready;
      if (wi >= nw && in_ready) extra = 1;
      if (in_valid && in_ready) wi++;
      if (out_valid && out_ready) got++;
      if (abort_at >= 0 && got == abort_at) break;
      @(posedge clk); #1;
      if (hdr_go) hdr_valid = 0;
      in_valid = wi < nw && $urandom_range(99) < in_pct;
      in_data = wi < nw ? payload[wi] : $urandom;
      out_ready = $urandom_range(99) < out_pct;
      cyc++;
    end
    @(posedge clk); #1;
    if (abort_at >= 0) begin
      rst = 0; hdr_valid = 0; in_valid = 0; out_ready = 0;
      #2;
      reset_checks({tag, "_midreset"});
      exp_q.delete();
      exp_err = 0;
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      return;
    end
    in_valid = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_pixels"}, got, 32);
    chk({tag, "_words"}, wi, nw);
    chk({tag, "_extra_req"}, extra, 0);
    chk({tag, "_leftover"}, exp_q.size(), 0);
    chk({tag, "_hdr_ready"}, hdr_ready, 1);
    chk({tag, "_err"}, err, exp_err);
  endtask
  initial begin
    header_t flat, r_only, w14, ovh;
    logic ov;
    flat = mk(10, 20, 30, 40, 4'b1111, 12'hFFF);
    r_only = mk(100, 20, 30, 40, 4'b0111, 12'h600);
    w14 = mk(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 4'b0000, 12'h6D2);
    ovh = mk(250, 20, 30, 40, 4'b0111, 12'h600);
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    foreach (payload[i]) payload[i] = '0;
    chk("model_flat", model_pixel(flat, 1, 5, ov), 32'h281E140A);
    run_block("flat", flat, 1, 100, 100, -1);
    foreach (payload[i]) payload[i] = 32'h04030201 + 32'(i);
    chk("model_raw", model_pixel(flat, 0, 3, ov), 32'h04030204);
    run_block("raw", flat, 0, 100, 100, -1);
    foreach (payload[i]) payload[i] = '0;
    payload[0] = 32'h76543210;
    chk("model_ronly", model_pixel(r_only, 1, 5, ov), 32'h281E1469);
    run_block("ronly", r_only, 1, 100, 100, -1);
    foreach (payload[i]) payload[i] = $urandom;
    chk("model_w14", pix_bits(w14, 1), 14);
    run_block("w14", w14, 1, 50, 50, -1);
    foreach (payload[i]) payload[i] = $urandom;
    run_block("abort", w14, 1, 70, 70, 11);
    foreach (payload[i]) payload[i] = '0;
    payload[0] = 32'h76543210;
    run_block("after_reset", r_only, 1, 60, 60, -1);
    foreach (payload[i]) payload[i] = '0;
    payload[0] = 32'h00000008;
    chk("model_ovf_pix", model_pixel(ovh, 1, 0, ov), 32'h281E1402);
    chk("model_ovf_flag", ov, 1);
    run_block("ovf", ovh, 1, 100, 100, -1);
    run_block("flat_after_ovf", flat, 1, 100, 80, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
